// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's control, instruction-memory and IF/ID signals.
// master = the fetch stage, slave = the surrounding pipeline and memory.
interface if_stage_if;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_pc4;
  logic [15:0] br_imm16;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [15:0] fetch_cnt;
  logic [15:0] bubble_cnt;

  modport master (
    input  stall, br_taken, br_pc4, br_imm16, imem_rdata,
    output imem_addr, ifid_inst, ifid_pc4, ifid_valid, fetch_cnt, bubble_cnt
  );

  modport slave (
    output stall, br_taken, br_pc4, br_imm16, imem_rdata,
    input  imem_addr, ifid_inst, ifid_pc4, ifid_valid, fetch_cnt, bubble_cnt
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and fetch/bubble counters.
// All state advances on the falling clock edge to line up with the other pipeline registers.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst_n,
  if_stage_if.master bus
);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] pc_plus4;

  // Offset has zero low bits, so masking the sum also discards br_pc4[1:0].
  assign br_offset = {{14{bus.br_imm16[15]}}, bus.br_imm16, 2'b00};
  assign br_target = (bus.br_pc4 + br_offset) & 32'hFFFF_FFFC;
  assign pc_plus4  = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    case (state_q)
      BOOT: begin
        inst_d       = NOP_INST;
        pc4_d        = 32'h0;
        valid_d      = 1'b0;
        bubble_cnt_d = (bubble_cnt_q == 16'hFFFF) ? bubble_cnt_q : bubble_cnt_q + 16'd1;
        state_d      = RUN;
      end
      RUN, FLUSH: begin
        if (bus.br_taken) begin
          pc_d         = br_target;
          inst_d       = NOP_INST;
          pc4_d        = 32'h0;
          valid_d      = 1'b0;
          bubble_cnt_d = (bubble_cnt_q == 16'hFFFF) ? bubble_cnt_q : bubble_cnt_q + 16'd1;
          state_d      = FLUSH;
        end else if (!bus.stall) begin
          pc_d        = pc_plus4;
          inst_d      = bus.imem_rdata;
          pc4_d       = pc_plus4;
          valid_d     = 1'b1;
          fetch_cnt_d = (fetch_cnt_q == 16'hFFFF) ? fetch_cnt_q : fetch_cnt_q + 16'd1;
          state_d     = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      pc4_q        <= 32'h0;
      valid_q      <= 1'b0;
      fetch_cnt_q  <= 16'h0;
      bubble_cnt_q <= 16'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.ifid_inst  = inst_q;
  assign bus.ifid_pc4   = pc4_q;
  assign bus.ifid_valid = valid_q;
  assign bus.fetch_cnt  = fetch_cnt_q;
  assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0000, instruction word inserted as a bubble (sll $0,$0,0).
REQ-003 clk  input  1  pipeline clock; all state updates on the falling edge of clk, matching the pipeline registers.
REQ-004 rst_n  input  1  reset; one clock, asynchronous and active-low.
REQ-005 stall  input  1  hold PC and IF/ID contents (load-use hazard from the stall unit).
REQ-006 br_taken  input  1  branch resolved taken in EX this cycle.
REQ-007 br_pc4  input  32  PC+4 of the branch instruction in EX.
REQ-008 br_imm16  input  16  branch offset field of the branch instruction in EX.
REQ-009 imem_addr  output  32  instruction memory word address (byte address, bits[1:0]=0).
REQ-010 imem_rdata  input  32  instruction memory read data, combinational from imem_addr.
REQ-011 ifid_inst  output  32  IF/ID instruction register.
REQ-012 ifid_pc4  output  32  IF/ID PC+4 register.
REQ-013 ifid_valid  output  1  IF/ID holds a real fetched instruction (0 = bubble).
REQ-014 fetch_cnt  output  16  count of instructions loaded into IF/ID with valid=1.
REQ-015 bubble_cnt  output  16  count of bubbles loaded into IF/ID (boot, flush).

Function
REQ-016 Internal PC register drives imem_addr directly; imem_addr SHALL equal PC at all times.
REQ-017 FSM states: BOOT, RUN, FLUSH; encoding free, exactly these three.
REQ-018 BOOT: entered on reset; on the first falling edge after rst_n rises, IF/ID <= bubble, PC unchanged, bubble_cnt +1, go to RUN.
REQ-019 RUN, br_taken=0, stall=0: IF/ID <= {imem_rdata, PC+4, valid=1}; PC <= PC+4; fetch_cnt +1; stay RUN.
REQ-020 RUN, stall=1, br_taken=0: PC, IF/ID, counters all hold; stay RUN.
REQ-021 RUN, br_taken=1 (regardless of stall): PC <= br_pc4 + ({{14{br_imm16[15]}}, br_imm16, 2'b00}); IF/ID <= bubble; bubble_cnt +1; go FLUSH.
REQ-022 FLUSH: behaves as RUN for the redirected fetch (REQ-019/020/021 apply), then returns to RUN; a second br_taken in FLUSH re-redirects and stays FLUSH.
REQ-023 Bubble = {ifid_inst=NOP_INST, ifid_pc4=32'h0, ifid_valid=0}.
REQ-024 Priority per edge: rst_n low > br_taken > stall > normal fetch.
REQ-025 All PC and target arithmetic modulo 2^32; PC 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 without error.
REQ-026 Target bits[1:0] are always 00 by construction; br_pc4[1:0] SHALL be ignored (treated as 00).
REQ-027 fetch_cnt and bubble_cnt saturate at 16'hFFFF, never wrap.
REQ-028 Fetch latency: instruction at PC appears on ifid_inst one falling edge after PC is presented, absent stall/branch.
REQ-029 No combinational path from stall or br_taken to ifid_* outputs; imem_addr depends only on PC register.

Reset
REQ-030 rst_n low SHALL asynchronously force PC=RESET_PC, state=BOOT, IF/ID=bubble, fetch_cnt=0, bubble_cnt=0.
REQ-031 Reset asserted mid-stall or mid-FLUSH SHALL discard all pending redirect/stall context; restart from BOOT.
REQ-032 Outputs SHALL be stable at reset values while rst_n low, regardless of clk, stall, br_taken.

Verification
REQ-033 Reset release, stall=0, imem returns addr-tagged words -> edge1 bubble, edge2 ifid_inst=mem[0], ifid_pc4=4, valid=1; edge3 mem[4], pc4=8.
REQ-034 Stall held 3 edges at PC=0x10 -> imem_addr stays 0x10, IF/ID and fetch_cnt unchanged; release -> fetch resumes at 0x10.
REQ-035 br_taken with br_pc4=0x20, br_imm16=16'hFFFE -> next PC=0x18, IF/ID bubble, bubble_cnt +1; following edge ifid_inst=mem[0x18], ifid_pc4=0x1C.
REQ-036 br_taken and stall both high, br_imm16=16'h0003, br_pc4=0x40 -> PC=0x4C, bubble inserted (branch wins).
REQ-037 PC preset via branch to 0xFFFFFFFC (br_pc4=0, imm16=16'hFFFF), normal fetch -> ifid_pc4=0x0, next imem_addr=0x0.
REQ-038 rst_n pulsed low between edges during FLUSH -> immediate PC=RESET_PC, counters 0, valid 0; sequence of REQ-033 repeats.
